// File: rtl/params_pkg.sv
// Shared widths and encodings for the ACE snoop path.
package params_pkg;

    localparam int unsigned SNOOP_ADD_BUS_WIDTH  = 32;
    localparam int unsigned SNOOP_DATA_BUS_WIDTH = 64;

    typedef enum logic [3:0] {
        AC_READ_ONCE             = 4'h0,
        AC_READ_SHARED           = 4'h1,
        AC_READ_CLEAN            = 4'h2,
        AC_READ_NOT_SHARED_DIRTY = 4'h3,
        AC_READ_UNIQUE           = 4'h7,
        AC_CLEAN_SHARED          = 4'h8,
        AC_CLEAN_INVALID         = 4'h9,
        AC_MAKE_INVALID          = 4'hD,
        AC_DVM_COMPLETE          = 4'hE,
        AC_DVM_MESSAGE           = 4'hF
    } ace_ac_snoop_e;

    typedef enum logic [2:0] {
        LS_I  = 3'd0,
        LS_UC = 3'd1,
        LS_UD = 3'd2,
        LS_SC = 3'd3,
        LS_SD = 3'd4
    } line_state_e;

    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } cr_resp_t;

endpackage

// File: rtl/ace_snoop_responder_if.sv
// Snoop channels (AC/CR/CD) plus the tag lookup and state update side bands.
interface ace_snoop_responder_if
    import params_pkg::*;
#(
    parameter int unsigned LINE_BEATS = 4
);
    logic                                       ac_valid;
    logic                                       ac_ready;
    logic [SNOOP_ADD_BUS_WIDTH-1:0]             ac_addr;
    logic [3:0]                                 ac_snoop;
    logic [2:0]                                 ac_prot;

    logic                                       cr_valid;
    logic                                       cr_ready;
    logic [4:0]                                 cr_resp;

    logic                                       cd_valid;
    logic                                       cd_ready;
    logic [SNOOP_DATA_BUS_WIDTH-1:0]            cd_data;
    logic                                       cd_last;

    logic                                       lk_req;
    logic [SNOOP_ADD_BUS_WIDTH-1:0]             lk_addr;
    logic                                       lk_valid;
    logic                                       lk_hit;
    logic [2:0]                                 lk_state;
    logic [LINE_BEATS*SNOOP_DATA_BUS_WIDTH-1:0] lk_line;

    logic                                       upd_valid;
    logic [SNOOP_ADD_BUS_WIDTH-1:0]             upd_addr;
    logic [2:0]                                 upd_state;

    modport slave (
        input  ac_valid, ac_addr, ac_snoop, ac_prot,
        output ac_ready,
        output cr_valid, cr_resp,
        input  cr_ready,
        output cd_valid, cd_data, cd_last,
        input  cd_ready,
        output lk_req, lk_addr,
        input  lk_valid, lk_hit, lk_state, lk_line,
        output upd_valid, upd_addr, upd_state
    );

    modport master (
        output ac_valid, ac_addr, ac_snoop, ac_prot,
        input  ac_ready,
        input  cr_valid, cr_resp,
        output cr_ready,
        input  cd_valid, cd_data, cd_last,
        output cd_ready,
        input  lk_req, lk_addr,
        output lk_valid, lk_hit, lk_state, lk_line,
        input  upd_valid, upd_addr, upd_state
    );

endinterface

// File: rtl/ace_snoop_responder.sv
// Single-outstanding ACE snoop responder: tag lookup, CR response, optional
// line data on CD, then an optional line-state update.
module ace_snoop_responder
    import params_pkg::*;
#(
    parameter int unsigned LINE_BEATS = 4
)(
    input  logic                  aclk,
    input  logic                  arst_n,
    ace_snoop_responder_if.slave  bus,
    output logic                  busy
);

    localparam int unsigned AW     = SNOOP_ADD_BUS_WIDTH;
    localparam int unsigned DW     = SNOOP_DATA_BUS_WIDTH;
    localparam int unsigned BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP,
        ST_DATA,
        ST_UPDATE
    } state_e;

    state_e            r_state;
    logic              r_ac_ready;
    logic [AW-1:0]     r_addr;
    logic [3:0]        r_snoop;
    logic [2:0]        r_ac_prot_unused;
    logic              r_lk_req;
    logic              r_cr_valid;
    cr_resp_t          r_cr_resp;
    logic [2:0]        r_new_state;
    logic              r_upd_needed;
    logic [DW-1:0]     r_beats [LINE_BEATS];
    logic [BEAT_W-1:0] r_beat;
    logic              r_cd_valid;
    logic [DW-1:0]     r_cd_data;
    logic              r_cd_last;
    logic              r_upd_valid;
    logic [2:0]        r_upd_state;
    logic              r_busy;

    cr_resp_t          w_resp;
    logic [2:0]        w_new_state;
    logic              w_hit;
    logic              w_unique;
    logic              w_dirty;
    logic              w_upd;
    logic [BEAT_W-1:0] w_next_beat;

    assign w_next_beat = r_beat + BEAT_W'(1);

    // Snoop response and next line state from the live lookup result.
    always_comb begin
        w_resp      = '0;
        w_new_state = bus.lk_state;
        w_hit       = bus.lk_hit && (bus.lk_state != LS_I) && (bus.lk_state <= LS_SD);
        w_unique    = (bus.lk_state == LS_UC) || (bus.lk_state == LS_UD);
        w_dirty     = (bus.lk_state == LS_UD) || (bus.lk_state == LS_SD);
        if (w_hit) begin
            case (r_snoop)
                AC_READ_ONCE: begin
                    w_resp.data_transfer = 1'b1;
                    w_resp.is_shared     = 1'b1;
                    w_resp.was_unique    = w_unique;
                end
                AC_READ_SHARED: begin
                    w_resp.data_transfer = 1'b1;
                    w_resp.is_shared     = 1'b1;
                    w_resp.pass_dirty    = w_dirty;
                    w_resp.was_unique    = w_unique;
                    w_new_state          = LS_SC;
                end
                AC_READ_CLEAN, AC_READ_NOT_SHARED_DIRTY: begin
                    w_resp.data_transfer = 1'b1;
                    w_resp.is_shared     = 1'b1;
                    w_resp.was_unique    = w_unique;
                    if (bus.lk_state == LS_UC)      w_new_state = LS_SC;
                    else if (bus.lk_state == LS_UD) w_new_state = LS_SD;
                end
                AC_READ_UNIQUE, AC_CLEAN_INVALID: begin
                    w_resp.data_transfer = 1'b1;
                    w_resp.pass_dirty    = w_dirty;
                    w_resp.was_unique    = w_unique;
                    w_new_state          = LS_I;
                end
                AC_CLEAN_SHARED: begin
                    w_resp.was_unique = w_unique;
                    if (w_dirty) begin
                        w_resp.data_transfer = 1'b1;
                        w_resp.pass_dirty    = 1'b1;
                        w_new_state = (bus.lk_state == LS_UD) ? LS_UC : LS_SC;
                    end else begin
                        w_resp.is_shared = 1'b1;
                    end
                end
                AC_MAKE_INVALID: begin
                    w_resp.was_unique = w_unique;
                    w_new_state       = LS_I;
                end
                default: w_new_state = bus.lk_state;
            endcase
        end
        w_upd = w_hit && (w_new_state != bus.lk_state);
    end

    // Main snoop FSM with registered outputs.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_state          <= ST_IDLE;
            r_ac_ready       <= 1'b0;
            r_addr           <= '0;
            r_snoop          <= '0;
            r_ac_prot_unused <= '0;
            r_lk_req         <= 1'b0;
            r_cr_valid       <= 1'b0;
            r_cr_resp        <= '0;
            r_new_state      <= '0;
            r_upd_needed     <= 1'b0;
            for (int b = 0; b < int'(LINE_BEATS); b++) r_beats[b] <= '0;
            r_beat           <= '0;
            r_cd_valid       <= 1'b0;
            r_cd_data        <= '0;
            r_cd_last        <= 1'b0;
            r_upd_valid      <= 1'b0;
            r_upd_state      <= '0;
            r_busy           <= 1'b0;
        end else begin
            r_lk_req    <= 1'b0;
            r_upd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ac_ready <= 1'b1;
                    if (bus.ac_valid && r_ac_ready) begin
                        r_ac_ready       <= 1'b0;
                        r_addr           <= bus.ac_addr;
                        r_snoop          <= bus.ac_snoop;
                        r_ac_prot_unused <= bus.ac_prot;
                        r_lk_req         <= 1'b1;
                        r_busy           <= 1'b1;
                        r_state          <= ST_LOOKUP;
                    end
                end
                // lk_valid during the request pulse belongs to an older lookup.
                ST_LOOKUP: begin
                    if (bus.lk_valid && !r_lk_req) begin
                        r_cr_resp    <= w_resp;
                        r_new_state  <= w_new_state;
                        r_upd_needed <= w_upd;
                        for (int b = 0; b < int'(LINE_BEATS); b++)
                            r_beats[b] <= bus.lk_line[b*DW +: DW];
                        r_cr_valid   <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.cr_ready) begin
                        r_cr_valid <= 1'b0;
                        if (r_cr_resp.data_transfer) begin
                            r_cd_valid <= 1'b1;
                            r_cd_data  <= r_beats[0];
                            r_cd_last  <= 1'(LINE_BEATS == 1);
                            r_beat     <= '0;
                            r_state    <= ST_DATA;
                        end else if (r_upd_needed) begin
                            r_upd_valid <= 1'b1;
                            r_upd_state <= r_new_state;
                            r_state     <= ST_UPDATE;
                        end else begin
                            r_ac_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.cd_ready) begin
                        if (r_cd_last) begin
                            r_cd_valid <= 1'b0;
                            r_cd_last  <= 1'b0;
                            if (r_upd_needed) begin
                                r_upd_valid <= 1'b1;
                                r_upd_state <= r_new_state;
                                r_state     <= ST_UPDATE;
                            end else begin
                                r_ac_ready <= 1'b1;
                                r_busy     <= 1'b0;
                                r_state    <= ST_IDLE;
                            end
                        end else begin
                            r_beat    <= w_next_beat;
                            r_cd_data <= r_beats[w_next_beat];
                            r_cd_last <= (w_next_beat == LAST_BEAT);
                        end
                    end
                end
                ST_UPDATE: begin
                    r_ac_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ac_ready  = r_ac_ready;
    assign bus.cr_valid  = r_cr_valid;
    assign bus.cr_resp   = r_cr_resp;
    assign bus.cd_valid  = r_cd_valid;
    assign bus.cd_data   = r_cd_data;
    assign bus.cd_last   = r_cd_last;
    assign bus.lk_req    = r_lk_req;
    assign bus.lk_addr   = r_addr;
    assign bus.upd_valid = r_upd_valid;
    assign bus.upd_addr  = r_addr;
    assign bus.upd_state = r_upd_state;
    assign busy          = r_busy;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder; the bench plays snooper, tag store and CR/CD sink.
module tb_ace_snoop_responder;
    import params_pkg::*;

    localparam int unsigned AW = SNOOP_ADD_BUS_WIDTH;
    localparam int unsigned DW = SNOOP_DATA_BUS_WIDTH;

    logic aclk;
    logic arst_n;
    logic busy;
    int   total;
    int   bad;

    ace_snoop_responder_if #(.LINE_BEATS(4)) bus ();

    ace_snoop_responder #(.LINE_BEATS(4)) dut (
        .aclk   (aclk),
        .arst_n (arst_n),
        .bus    (bus),
        .busy   (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Hit snoops that move data: snoop, looked-up state, response, update?, new state.
    logic [3:0] tv_snoop [7] = '{4'h1, 4'h2, 4'h3, 4'h7, 4'h9, 4'h8, 4'h0};
    logic [2:0] tv_state [7] = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd4};
    logic [4:0] tv_resp  [7] = '{5'b11101, 5'b11001, 5'b01001, 5'b00101, 5'b10001, 5'b10101, 5'b01001};
    logic       tv_upd   [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] tv_ns    [7] = '{3'd3, 3'd4, 3'd3, 3'd0, 3'd0, 3'd1, 3'd4};

    logic [DW-1:0]   beats [4];
    logic [4*DW-1:0] line;

    task automatic make_line(input int tag);
        for (int k = 0; k < 4; k++) beats[k] = DW'({16'hA5A5, 8'(tag), 8'(k)});
        line = {beats[3], beats[2], beats[1], beats[0]};
    endtask

    task automatic send_snoop(input logic [AW-1:0] a, input logic [3:0] s);
        for (int n = 0; n < 30 && bus.ac_ready !== 1'b1; n++) @(negedge aclk);
        total++;
        if (bus.ac_ready !== 1'b1) begin
            bad++;
            $display("FAIL ac_ready_wait: ac_ready=%b required 1", bus.ac_ready);
        end
        bus.ac_valid = 1'b1;
        bus.ac_addr  = a;
        bus.ac_snoop = s;
        bus.ac_prot  = 3'b010;
        @(negedge aclk);
        bus.ac_valid = 1'b0;
    endtask

    // Called in the lk_req cycle; optionally drives a stale miss there that must be ignored.
    task automatic give_lookup(input logic hit, input logic [2:0] st, input bit early);
        if (early) begin
            bus.lk_valid = 1'b1;
            bus.lk_hit   = 1'b0;
            bus.lk_state = 3'd0;
            bus.lk_line  = '0;
        end
        @(negedge aclk);
        bus.lk_valid = 1'b1;
        bus.lk_hit   = hit;
        bus.lk_state = st;
        bus.lk_line  = line;
        @(negedge aclk);
        bus.lk_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge aclk);
        total++;
        if ({bus.ac_ready, busy, bus.cr_valid, bus.cd_valid, bus.cd_last, bus.lk_req, bus.upd_valid} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b need 0000000",
                     {bus.ac_ready, busy, bus.cr_valid, bus.cd_valid, bus.cd_last, bus.lk_req, bus.upd_valid});
        end
        total++;
        if ({bus.cr_resp, bus.upd_state, bus.cd_data, bus.upd_addr, bus.lk_addr} !== '0) begin
            bad++;
            $display("FAIL reset_data: resp=%b upd_state=%0d cd_data=%h upd_addr=%h lk_addr=%h need all 0",
                     bus.cr_resp, bus.upd_state, bus.cd_data, bus.upd_addr, bus.lk_addr);
        end
        arst_n = 1'b1;
        @(negedge aclk);
        total++;
        if ({bus.ac_ready, busy} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: ac_ready,busy=%b need 10", {bus.ac_ready, busy});
        end
    endtask

    task automatic test_data_snoops();
        logic [AW-1:0] a;
        for (int i = 0; i < 7; i++) begin
            a = AW'(32'h0000_1000 + 32'(i * 64));
            make_line(i);
            send_snoop(a, tv_snoop[i]);
            total++;
            if ({bus.lk_req, busy, bus.ac_ready, bus.lk_addr} !== {3'b110, a}) begin
                bad++;
                $display("FAIL lk_req[%0d]: req,busy,ready=%b addr=%h need 110 %h",
                         i, {bus.lk_req, busy, bus.ac_ready}, bus.lk_addr, a);
            end
            give_lookup(1'b1, tv_state[i], i == 0);
            total++;
            if ({bus.cr_valid, bus.cr_resp, bus.lk_req} !== {1'b1, tv_resp[i], 1'b0}) begin
                bad++;
                $display("FAIL cr_resp[%0d]: valid=%b resp=%b need 1 %b", i, bus.cr_valid, bus.cr_resp, tv_resp[i]);
            end
            bus.cr_ready = 1'b1;
            @(negedge aclk);
            bus.cr_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                total++;
                if ({bus.cd_valid, bus.cd_last, bus.cd_data} !== {1'b1, k == 3, beats[k]}) begin
                    bad++;
                    $display("FAIL cd_beat[%0d.%0d]: valid=%b last=%b data=%h need 1 %b %h",
                             i, k, bus.cd_valid, bus.cd_last, bus.cd_data, k == 3, beats[k]);
                end
                bus.cd_ready = 1'b1;
                @(negedge aclk);
            end
            bus.cd_ready = 1'b0;
            if (tv_upd[i]) begin
                total++;
                if ({bus.cd_valid, bus.upd_valid, bus.upd_state, bus.upd_addr} !== {2'b01, tv_ns[i], a}) begin
                    bad++;
                    $display("FAIL upd[%0d]: cd_valid=%b upd_valid=%b state=%0d addr=%h need 0 1 %0d %h",
                             i, bus.cd_valid, bus.upd_valid, bus.upd_state, bus.upd_addr, tv_ns[i], a);
                end
                @(negedge aclk);
            end
            total++;
            if ({bus.cd_valid, bus.upd_valid, bus.ac_ready, busy} !== 4'b0010) begin
                bad++;
                $display("FAIL idle_after[%0d]: cd_valid,upd_valid,ac_ready,busy=%b need 0010",
                         i, {bus.cd_valid, bus.upd_valid, bus.ac_ready, busy});
            end
        end
    endtask

    // Misses (no hit, hit on I, hit on illegal state) and DVM snoops all answer zero.
    task automatic test_miss();
        logic [3:0] m_snoop [5] = '{4'h7, 4'h1, 4'h1, 4'hE, 4'hF};
        logic       m_hit   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [2:0] m_state [5] = '{3'd2, 3'd0, 3'd5, 3'd2, 3'd1};
        make_line(9);
        for (int i = 0; i < 5; i++) begin
            send_snoop(AW'(32'h0000_2000 + 32'(i * 64)), m_snoop[i]);
            give_lookup(m_hit[i], m_state[i], 1'b0);
            total++;
            if ({bus.cr_valid, bus.cr_resp} !== 6'b100000) begin
                bad++;
                $display("FAIL miss_resp[%0d]: valid=%b resp=%b need 1 00000", i, bus.cr_valid, bus.cr_resp);
            end
            bus.cr_ready = 1'b1;
            @(negedge aclk);
            bus.cr_ready = 1'b0;
            total++;
            if ({bus.cd_valid, bus.upd_valid, bus.ac_ready, busy} !== 4'b0010) begin
                bad++;
                $display("FAIL miss_gap[%0d]: cd_valid,upd_valid,ac_ready,busy=%b need 0010",
                         i, {bus.cd_valid, bus.upd_valid, bus.ac_ready, busy});
            end
            @(negedge aclk);
            total++;
            if ({bus.cd_valid, bus.upd_valid} !== 2'b00) begin
                bad++;
                $display("FAIL miss_quiet[%0d]: cd_valid,upd_valid=%b need 00", i, {bus.cd_valid, bus.upd_valid});
            end
        end
    endtask

    task automatic test_clean_shared_sc();
        make_line(10);
        send_snoop(AW'(32'h0000_3000), 4'h8);
        give_lookup(1'b1, 3'd3, 1'b0);
        total++;
        if ({bus.cr_valid, bus.cr_resp} !== 6'b101000) begin
            bad++;
            $display("FAIL cs_sc_resp: valid=%b resp=%b need 1 01000", bus.cr_valid, bus.cr_resp);
        end
        bus.cr_ready = 1'b1;
        @(negedge aclk);
        bus.cr_ready = 1'b0;
        total++;
        if ({bus.cd_valid, bus.upd_valid, bus.ac_ready} !== 3'b001) begin
            bad++;
            $display("FAIL cs_sc_after: cd_valid,upd_valid,ac_ready=%b need 001", {bus.cd_valid, bus.upd_valid, bus.ac_ready});
        end
    endtask

    task automatic test_read_once_stall();
        int  k;
        logic rdy;
        k = 0;
        make_line(11);
        send_snoop(AW'(32'h0000_4000), 4'h0);
        give_lookup(1'b1, 3'd1, 1'b0);
        total++;
        if ({bus.cr_valid, bus.cr_resp} !== 6'b111001) begin
            bad++;
            $display("FAIL ro_resp: valid=%b resp=%b need 1 11001", bus.cr_valid, bus.cr_resp);
        end
        bus.cr_ready = 1'b1;
        @(negedge aclk);
        bus.cr_ready = 1'b0;
        for (int n = 0; n < 40 && k < 4; n++) begin
            total++;
            if ({bus.cd_valid, bus.cd_last, bus.cd_data} !== {1'b1, k == 3, beats[k]}) begin
                bad++;
                $display("FAIL ro_beat[%0d cyc %0d]: valid=%b last=%b data=%h need 1 %b %h",
                         k, n, bus.cd_valid, bus.cd_last, bus.cd_data, k == 3, beats[k]);
            end
            rdy = (n % 3 == 0);
            bus.cd_ready = rdy;
            @(negedge aclk);
            if (rdy) k++;
        end
        bus.cd_ready = 1'b0;
        total++;
        if (k != 4 || {bus.cd_valid, bus.upd_valid, bus.ac_ready} !== 3'b001) begin
            bad++;
            $display("FAIL ro_end: beats=%0d cd_valid,upd_valid,ac_ready=%b need 4 001",
                     k, {bus.cd_valid, bus.upd_valid, bus.ac_ready});
        end
    endtask

    task automatic test_make_invalid_cr_stall();
        logic [AW-1:0] a;
        a = AW'(32'h0000_5040);
        make_line(12);
        send_snoop(a, 4'hD);
        give_lookup(1'b1, 3'd4, 1'b0);
        for (int n = 0; n < 5; n++) begin
            total++;
            if ({bus.cr_valid, bus.cr_resp} !== 6'b100000) begin
                bad++;
                $display("FAIL mi_hold[%0d]: valid=%b resp=%b need 1 00000", n, bus.cr_valid, bus.cr_resp);
            end
            @(negedge aclk);
        end
        bus.cr_ready = 1'b1;
        @(negedge aclk);
        bus.cr_ready = 1'b0;
        total++;
        if ({bus.cr_valid, bus.cd_valid, bus.upd_valid, bus.upd_state, bus.upd_addr} !== {3'b001, 3'd0, a}) begin
            bad++;
            $display("FAIL mi_upd: cr_valid=%b cd_valid=%b upd_valid=%b state=%0d addr=%h need 0 0 1 0 %h",
                     bus.cr_valid, bus.cd_valid, bus.upd_valid, bus.upd_state, bus.upd_addr, a);
        end
        @(negedge aclk);
        total++;
        if ({bus.upd_valid, bus.ac_ready} !== 2'b01) begin
            bad++;
            $display("FAIL mi_after: upd_valid,ac_ready=%b need 01", {bus.upd_valid, bus.ac_ready});
        end
    endtask

    task automatic test_reset_mid_data();
        logic [AW-1:0] a;
        make_line(13);
        send_snoop(AW'(32'h0000_6000), 4'h1);
        give_lookup(1'b1, 3'd2, 1'b0);
        bus.cr_ready = 1'b1;
        @(negedge aclk);
        bus.cr_ready = 1'b0;
        bus.cd_ready = 1'b1;
        repeat (2) @(negedge aclk);
        bus.cd_ready = 1'b0;
        total++;
        if ({bus.cd_valid, bus.cd_data} !== {1'b1, beats[2]}) begin
            bad++;
            $display("FAIL rst_pre: valid=%b data=%h need 1 %h", bus.cd_valid, bus.cd_data, beats[2]);
        end
        arst_n = 1'b0;
        #1;
        total++;
        if ({bus.cd_valid, bus.cd_last, bus.upd_valid, bus.cr_valid, busy, bus.ac_ready} !== 6'b0) begin
            bad++;
            $display("FAIL rst_now: cd_valid,cd_last,upd_valid,cr_valid,busy,ac_ready=%b need 000000",
                     {bus.cd_valid, bus.cd_last, bus.upd_valid, bus.cr_valid, busy, bus.ac_ready});
        end
        repeat (2) @(negedge aclk);
        arst_n = 1'b1;
        @(negedge aclk);
        total++;
        if ({bus.cd_valid, bus.upd_valid, bus.ac_ready} !== 3'b001) begin
            bad++;
            $display("FAIL rst_after: cd_valid,upd_valid,ac_ready=%b need 001", {bus.cd_valid, bus.upd_valid, bus.ac_ready});
        end
        // The following ReadClean on a UC line must run normally.
        a = AW'(32'h0000_7000);
        make_line(14);
        send_snoop(a, 4'h2);
        give_lookup(1'b1, 3'd1, 1'b0);
        total++;
        if ({bus.cr_valid, bus.cr_resp} !== 6'b111001) begin
            bad++;
            $display("FAIL rst_next_resp: valid=%b resp=%b need 1 11001", bus.cr_valid, bus.cr_resp);
        end
        bus.cr_ready = 1'b1;
        @(negedge aclk);
        bus.cr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({bus.cd_valid, bus.cd_last, bus.cd_data} !== {1'b1, k == 3, beats[k]}) begin
                bad++;
                $display("FAIL rst_next_beat[%0d]: valid=%b last=%b data=%h need 1 %b %h",
                         k, bus.cd_valid, bus.cd_last, bus.cd_data, k == 3, beats[k]);
            end
            bus.cd_ready = 1'b1;
            @(negedge aclk);
        end
        bus.cd_ready = 1'b0;
        total++;
        if ({bus.upd_valid, bus.upd_state, bus.upd_addr} !== {1'b1, 3'd3, a}) begin
            bad++;
            $display("FAIL rst_next_upd: valid=%b state=%0d addr=%h need 1 3 %h",
                     bus.upd_valid, bus.upd_state, bus.upd_addr, a);
        end
        @(negedge aclk);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        arst_n       = 1'b0;
        bus.ac_valid = 1'b0;
        bus.ac_addr  = '0;
        bus.ac_snoop = '0;
        bus.ac_prot  = '0;
        bus.cr_ready = 1'b0;
        bus.cd_ready = 1'b0;
        bus.lk_valid = 1'b0;
        bus.lk_hit   = 1'b0;
        bus.lk_state = '0;
        bus.lk_line  = '0;
        test_reset();
        test_data_snoops();
        test_miss();
        test_clean_shared_sc();
        test_read_once_stall();
        test_make_invalid_cr_stall();
        test_reset_mid_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
